count_seq_ctrl: RTL and testbench

Run-control sequencer for the up/down counter datapath that feeds the LED bank and the 7-segment driver. It turns start/stop/clear button presses and a rate select into single-cycle count-enable strobes, a clear strobe and a latched direction. All logic runs on the board clock. The block removes the derived divider clock: the counter clocks on clk and steps only on cnt_en. It supports free-run mode, with wrap handled by the counter, and one-shot mode, which stops after a programmed number of steps.

---
 rtl/count_seq_ctrl_if.sv | 37 +++
 rtl/count_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_count_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : count_seq_ctrl_if
// Purpose  : Button/rate/mode inputs and counter-control outputs of the
//            run-control sequencer, bundled with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface count_seq_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             btn_start;
    logic             btn_stop;
    logic             btn_clr;
    logic [4:0]       s;
    logic             dir;
    logic             oneshot;
    logic [CNT_W-1:0] limit;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_dir;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    // Driver side: buttons and configuration in, counter control back.
    modport master (
        output btn_start, btn_stop, btn_clr, s, dir, oneshot, limit,
        input  cnt_en, cnt_clr, cnt_dir, state, busy, done
    );

    // Sequencer side.
    modport slave (
        input  btn_start, btn_stop, btn_clr, s, dir, oneshot, limit,
        output cnt_en, cnt_clr, cnt_dir, state, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_seq_ctrl
// Purpose  : Run-control sequencer for the up/down counter. Converts start,
//            stop and clear button presses plus a rate select into one-cycle
//            count-enable and clear strobes and a latched direction. Supports
//            free-run and one-shot (limited step count) operation.
// Revision : 1.0 - initial release
// ============================================================================
module count_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int PRE_W = 32
) (
    input wire              clk,
    input wire              rst,
    count_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0] c_pre_one  = PRE_W'(1);
    localparam logic [CNT_W-1:0] c_step_one = CNT_W'(1);

    state_t             r_state;
    logic               r_start_d;
    logic               r_stop_d;
    logic               r_clr_d;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_step;
    logic               r_oneshot;
    logic [CNT_W-1:0]   r_limit;
    logic               r_cnt_en;
    logic               r_cnt_clr;
    logic               r_cnt_dir;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic [CNT_W-1:0]   w_step_nxt;
    logic               w_oneshot_nxt;
    logic [CNT_W-1:0]   w_limit_nxt;
    logic               w_en_nxt;
    logic               w_clr_nxt;
    logic               w_dir_nxt;

    logic               w_start_act;
    logic               w_stop_act;
    logic               w_clr_act;
    logic [PRE_W-1:0]   w_mask;
    logic               w_tick;
    logic [CNT_W-1:0]   w_step_inc;

    // Rising-edge press detection with clr > stop > start arbitration; a lower
    // press is dropped whenever a higher one coincides, even if that higher
    // press has no effect in the current state.
    assign w_clr_act   = bus.btn_clr & ~r_clr_d;
    assign w_stop_act  = bus.btn_stop & ~r_stop_d & ~w_clr_act;
    assign w_start_act = bus.btn_start & ~r_start_d & ~w_clr_act
                         & ~(bus.btn_stop & ~r_stop_d);

    // Rate tick: low s bits of the prescaler all ones while running.
    assign w_mask     = (c_pre_one << bus.s) - c_pre_one;
    assign w_tick     = (r_state == ST_RUN) && ((r_pre & w_mask) == w_mask);
    assign w_step_inc = r_step + c_step_one;

    // State, datapath registers and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_stop_d  <= 1'b0;
            r_clr_d   <= 1'b0;
            r_pre     <= '0;
            r_step    <= '0;
            r_oneshot <= 1'b0;
            r_limit   <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_cnt_dir <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= bus.btn_start;
            r_stop_d  <= bus.btn_stop;
            r_clr_d   <= bus.btn_clr;
            r_pre     <= w_pre_nxt;
            r_step    <= w_step_nxt;
            r_oneshot <= w_oneshot_nxt;
            r_limit   <= w_limit_nxt;
            r_cnt_en  <= w_en_nxt;
            r_cnt_clr <= w_clr_nxt;
            r_cnt_dir <= w_dir_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state, prescaler/step-counter and strobe decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre;
        w_step_nxt    = r_step;
        w_oneshot_nxt = r_oneshot;
        w_limit_nxt   = r_limit;
        w_en_nxt      = 1'b0;
        w_clr_nxt     = 1'b0;
        w_dir_nxt     = r_cnt_dir;

        if (w_clr_act) begin
            w_state_nxt = ST_IDLE;
            w_clr_nxt   = 1'b1;
            w_pre_nxt   = '0;
            w_step_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_act) begin
                        w_dir_nxt     = bus.dir;
                        w_oneshot_nxt = bus.oneshot;
                        w_limit_nxt   = bus.limit;
                        w_pre_nxt     = '0;
                        w_step_nxt    = '0;
                        // Restarting after completion zeroes the counter.
                        w_clr_nxt     = (r_state == ST_DONE);
                        // A zero-step one-shot completes immediately.
                        if (bus.oneshot && (bus.limit == '0)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_stop_act) begin
                        // Prescaler frozen so a resume continues the period
                        // and a coincident tick is retried after resume.
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_pre_nxt = r_pre + c_pre_one;
                        if (w_tick) begin
                            w_en_nxt   = 1'b1;
                            w_step_nxt = w_step_inc;
                            if (r_oneshot && (w_step_inc == r_limit)) begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_start_act) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_en  = r_cnt_en;
    assign bus.cnt_clr = r_cnt_clr;
    assign bus.cnt_dir = r_cnt_dir;
    assign bus.state   = r_state;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_seq_ctrl
// Purpose  : Self-checking bench for count_seq_ctrl: a per-cycle vector table
//            followed by directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_seq_ctrl;

    typedef struct {
        logic       st;
        logic       sp;
        logic       cl;
        logic [4:0] s;
        logic       dir;
        logic       os;
        logic [7:0] lim;
        logic [1:0] e_state;
        logic       e_en;
        logic       e_clr;
        logic       e_dir;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vq[$];

    count_seq_ctrl_if #(.CNT_W(8)) bus ();

    count_seq_ctrl #(.CNT_W(8), .PRE_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic sp, input logic cl,
                       input logic [4:0] s, input logic dir, input logic os,
                       input logic [7:0] lim, input logic [1:0] e_state,
                       input logic e_en, input logic e_clr, input logic e_dir,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.s = s; v.dir = dir; v.os = os;
        v.lim = lim; v.e_state = e_state; v.e_en = e_en; v.e_clr = e_clr;
        v.e_dir = e_dir; v.e_busy = e_busy; v.e_done = e_done;
        vq.push_back(v);
    endtask

    function automatic int outs();
        return int'({bus.state, bus.cnt_en, bus.cnt_clr, bus.cnt_dir,
                     bus.busy, bus.done});
    endfunction

    task automatic wait_en(input int max, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= max; i++) begin
            if (!found) begin
                tick();
                if (bus.cnt_en) begin
                    n = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic run_count(input int cyc, output int n_en, output int n_clr,
                             output int n_dbl);
        logic prev;
        n_en = 0; n_clr = 0; n_dbl = 0;
        prev = bus.cnt_en;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (bus.cnt_en) n_en++;
            if (bus.cnt_clr) n_clr++;
            if (bus.cnt_en && prev) n_dbl++;
            prev = bus.cnt_en;
        end
    endtask

    task automatic press_clr();
        bus.btn_clr = 1'b1;
        tick();
        bus.btn_clr = 1'b0;
        tick();
    endtask

    task automatic press_start();
        bus.btn_start = 1'b1;
        tick();
    endtask

    // Stimulus and checking.
    initial begin
        int n, ne, nc, nd;
        int exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_clr = 1'b0;
        bus.s = 5'd2; bus.dir = 1'b1; bus.oneshot = 1'b0; bus.limit = 8'd0;

        // st sp cl s dir os lim | state en clr dir busy done
        add(0,0,0, 2,1,0,0,  0,0,0,0,0,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,1,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,1,0,0,  1,1,0,1,1,0);
        add(0,1,0, 2,1,0,0,  2,0,0,1,0,0);
        add(0,1,0, 2,1,0,0,  2,0,0,1,0,0);
        add(1,0,0, 2,0,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,0,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,0,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,0,0,0,  1,0,0,1,1,0);
        add(1,0,0, 2,0,0,0,  1,1,0,1,1,0);
        add(0,0,1, 2,0,0,0,  0,0,1,1,0,0);
        add(0,0,1, 2,0,0,0,  0,0,0,1,0,0);
        add(0,0,0, 2,0,0,0,  0,0,0,1,0,0);
        add(1,0,0, 2,0,1,0,  3,0,0,0,0,1);
        add(0,0,0, 2,0,1,0,  3,0,0,0,0,1);
        add(1,0,0, 2,0,1,0,  3,0,1,0,0,1);
        add(0,0,0, 2,0,1,0,  3,0,0,0,0,1);
        add(1,0,0, 0,1,0,0,  1,0,1,1,1,0);
        add(1,0,0, 0,1,0,0,  1,1,0,1,1,0);
        add(1,0,0, 0,1,0,0,  1,1,0,1,1,0);
        add(0,1,0, 0,1,0,0,  2,0,0,1,0,0);
        add(0,0,0, 0,1,0,0,  2,0,0,1,0,0);
        add(0,0,1, 0,1,0,0,  0,0,1,1,0,0);
        add(0,1,0, 0,1,0,0,  0,0,0,1,0,0);
        add(0,0,0, 0,1,0,0,  0,0,0,1,0,0);

        repeat (3) tick();
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            bus.btn_start = vq[i].st; bus.btn_stop = vq[i].sp;
            bus.btn_clr   = vq[i].cl; bus.s = vq[i].s; bus.dir = vq[i].dir;
            bus.oneshot   = vq[i].os; bus.limit = vq[i].lim;
            tick();
            exp = int'({vq[i].e_state, vq[i].e_en, vq[i].e_clr, vq[i].e_dir,
                        vq[i].e_busy, vq[i].e_done});
            chk($sformatf("vec%0d", i), outs(), exp);
        end
        bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_clr = 1'b0;

        // Free run, s=2: first strobe 4 cycles after entry, then every 4.
        press_clr();
        bus.s = 5'd2; bus.dir = 1'b1; bus.oneshot = 1'b0;
        press_start();
        chk("fr_state_run", int'(bus.state), 1);
        bus.btn_start = 1'b0;
        wait_en(20, n);
        chk("fr_first_gap", n, 4);
        run_count(36, ne, nc, nd);
        chk("fr_pulses", ne + 1, 10);
        chk("fr_wide_pulse", nd, 0);
        chk("fr_dir", int'(bus.cnt_dir), 1);

        // Pause mid-period; resume finishes the residual count.
        press_clr();
        bus.s = 5'd3;
        press_start();
        bus.btn_start = 1'b0;
        wait_en(20, n);
        chk("pz_gap1", n, 8);
        wait_en(20, n);
        chk("pz_gap2", n, 8);
        run_count(3, ne, nc, nd);
        chk("pz_run_quiet", ne, 0);
        bus.btn_stop = 1'b1;
        tick();
        bus.btn_stop = 1'b0;
        chk("pz_state_pause", int'(bus.state), 2);
        run_count(20, ne, nc, nd);
        chk("pz_no_en", ne, 0);
        press_start();
        bus.btn_start = 1'b0;
        chk("pz_resume", int'(bus.state), 1);
        wait_en(20, n);
        chk("pz_residual", n, 5);

        // One-shot of 5 steps at s=1, then restart from DONE.
        press_clr();
        bus.s = 5'd1; bus.oneshot = 1'b1; bus.limit = 8'd5;
        press_start();
        bus.btn_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_en(10, n);
            chk($sformatf("os_gap%0d", k), n, 2);
        end
        chk("os_done_state", int'(bus.state), 3);
        chk("os_done_flag", int'(bus.done), 1);
        run_count(20, ne, nc, nd);
        chk("os_no_extra", ne, 0);
        press_start();
        bus.btn_start = 1'b0;
        chk("os_restart_clr", int'(bus.cnt_clr), 1);
        chk("os_restart_run", int'(bus.state), 1);
        run_count(20, ne, nc, nd);
        chk("os_second_pulses", ne, 5);
        chk("os_second_clr", nc, 0);
        chk("os_second_done", int'(bus.state), 3);

        // One-shot with zero limit completes at once.
        press_clr();
        bus.oneshot = 1'b1; bus.limit = 8'd0;
        press_start();
        bus.btn_start = 1'b0;
        chk("z_state", int'(bus.state), 3);
        chk("z_done", int'(bus.done), 1);
        run_count(10, ne, nc, nd);
        chk("z_no_en", ne, 0);

        // All three buttons together in RUN: clear wins, holding is inert.
        press_clr();
        bus.oneshot = 1'b0; bus.s = 5'd2;
        press_start();
        bus.btn_start = 1'b0;
        run_count(6, ne, nc, nd);
        bus.btn_start = 1'b1; bus.btn_stop = 1'b1; bus.btn_clr = 1'b1;
        tick();
        chk("all3_state", int'(bus.state), 0);
        chk("all3_clr", int'(bus.cnt_clr), 1);
        chk("all3_en", int'(bus.cnt_en), 0);
        run_count(10, ne, nc, nd);
        chk("all3_hold_quiet", ne + nc, 0);
        chk("all3_hold_state", int'(bus.state), 0);
        bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
